tx_frame_ctrl: RTL and testbench



---
 rtl/tx_frame_ctrl_if.sv | 24 ++
 rtl/tx_frame_ctrl.sv | 112 +++++++++++
 tb/tb_tx_frame_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/tx_frame_ctrl_if.sv
// Handshake bundle between the upstream word producer, the TX frame sequencer and the TX output mux.
// master = producer side, slave = tx_frame_ctrl.
interface tx_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [1:0]            MUX_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  MUX_sel, ser_data, par_bit, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output MUX_sel, ser_data, par_bit, busy
  );
endinterface

// File: rtl/tx_frame_ctrl.sv
// UART transmit frame sequencer: start / LSB-first data / optional parity / stop, one bit per CLK.
// Define TX_BACK_TO_BACK_EN to accept a new word in STOP and start the next frame with no idle gap.
module tx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  tx_frame_ctrl_if.slave bus
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DATA_WIDTH - 1);

  localparam logic [1:0] SelStart  = 2'b00;
  localparam logic [1:0] SelStop   = 2'b01;
  localparam logic [1:0] SelData   = 2'b10;
  localparam logic [1:0] SelParity = 2'b11;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            mux_sel_q, mux_sel_d;
  logic                  ser_data_q, ser_data_d;
  logic                  par_bit_q, par_bit_d;
  logic                  busy_q, busy_d;
  logic                  accept;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    cnt_d     = cnt_q;

`ifdef TX_BACK_TO_BACK_EN
    accept = bus.Data_Valid && ((state_q == StIdle) || (state_q == StStop));
`else
    accept = bus.Data_Valid && (state_q == StIdle);
`endif

    unique case (state_q)
      StIdle:   state_d = StIdle;
      StStart: begin
        state_d = StData;
        cnt_d   = '0;
      end
      StData: begin
        if (cnt_q == CntMax) begin
          state_d = par_en_q ? StParity : StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: state_d = StStop;
      StStop:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (accept) begin
      state_d   = StStart;
      data_d    = bus.P_DATA;
      par_en_d  = bus.PAR_EN;
      par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
      cnt_d     = '0;
    end

    // Outputs are decoded from the next state so every output pin is a flop aligned with state_q.
    mux_sel_d  = SelStop;
    ser_data_d = 1'b0;
    busy_d     = (state_d != StIdle);
    case (state_d)
      StStart:  mux_sel_d = SelStart;
      StData: begin
        mux_sel_d  = SelData;
        ser_data_d = data_d[cnt_d];
      end
      StParity: mux_sel_d = SelParity;
      default:  mux_sel_d = SelStop;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      cnt_q      <= '0;
      mux_sel_q  <= SelStop;
      ser_data_q <= 1'b0;
      par_bit_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      cnt_q      <= cnt_d;
      mux_sel_q  <= mux_sel_d;
      ser_data_q <= ser_data_d;
      par_bit_q  <= par_bit_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.MUX_sel  = mux_sel_q;
  assign bus.ser_data = ser_data_q;
  assign bus.par_bit  = par_bit_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Self-checking bench for tx_frame_ctrl: a per-cycle stimulus list paired with expected line
// behaviour built from whole-frame descriptions (start, data LSB first, parity, stop).
module tb_tx_frame_ctrl;

  localparam int unsigned DW = 8;

  typedef struct packed {
    logic          rst;
    logic          dv;
    logic [DW-1:0] d;
    logic          en;
    logic          typ;
  } stim_t;

  typedef struct packed {
    logic [1:0] mux;
    logic       ser;
    logic       busy;
    logic       par;
  } obs_t;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  tx_frame_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  stim_t stim_q[$];
  obs_t  exp_q[$];
  logic  last_par;
  int    compared   = 0;
  int    mismatched = 0;

  task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  function automatic stim_t rnd_stim();
    stim_t s;
    s.rst = 1'b0;
    s.dv  = 1'($urandom_range(0, 1));
    s.d   = DW'($urandom);
    s.en  = 1'($urandom_range(0, 1));
    s.typ = 1'($urandom_range(0, 1));
    return s;
  endfunction

  function automatic void push(input stim_t s, input obs_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endfunction

  // One whole frame: entry 0 carries the accept stimulus, later entries carry filler.
  function automatic void add_frame(input logic [DW-1:0] w, input logic en, input logic typ,
                                    input logic rnd, input stim_t filler);
    stim_t acc;
    logic  p;
    p   = (^w) ^ typ;
    acc = '{rst: 1'b0, dv: 1'b1, d: w, en: en, typ: typ};
    push(acc, '{mux: 2'b00, ser: 1'b0, busy: 1'b1, par: p});
    for (int i = 0; i < DW; i++) begin
      push(rnd ? rnd_stim() : filler, '{mux: 2'b10, ser: w[i], busy: 1'b1, par: p});
    end
    if (en) push(rnd ? rnd_stim() : filler, '{mux: 2'b11, ser: 1'b0, busy: 1'b1, par: p});
    push(rnd ? rnd_stim() : filler, '{mux: 2'b01, ser: 1'b0, busy: 1'b1, par: p});
    last_par = p;
  endfunction

  function automatic void add_idle(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s    = rnd_stim();
      s.dv = 1'b0;
      push(s, '{mux: 2'b01, ser: 1'b0, busy: 1'b0, par: last_par});
    end
  endfunction

  function automatic void add_reset();
    stim_t s;
    s     = rnd_stim();
    s.rst = 1'b1;
    s.dv  = 1'b1;
    push(s, '{mux: 2'b01, ser: 1'b0, busy: 1'b0, par: 1'b0});
    last_par = 1'b0;
  endfunction

  initial begin
    stim_t quiet, hold, tmp;
    obs_t  o, e;
    int    base;

    RST            = 1'b1;
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    last_par       = 1'b0;
    quiet          = '{rst: 1'b0, dv: 1'b0, d: '0, en: 1'b0, typ: 1'b0};

    // Reset (with a request that must be ignored), then a long quiet idle.
    add_reset();
    add_reset();
    add_idle(20);

    // Even parity 0xA5, odd parity 0x01, then 0x01 without parity.
    add_frame(8'hA5, 1'b1, 1'b0, 1'b0, quiet);
    add_idle(2);
    add_frame(8'h01, 1'b1, 1'b1, 1'b0, quiet);
    add_idle(1);
    add_frame(8'h01, 1'b0, 1'b1, 1'b0, quiet);
    add_idle(2);

    // Request for 0xFF pulsed during the 4th data cycle of a 0x00 frame.
    base = stim_q.size();
    add_frame(8'h00, 1'b1, 1'b0, 1'b0, quiet);
    tmp    = stim_q[base + 5];
    tmp.dv = 1'b1;
    tmp.d  = 8'hFF;
    stim_q[base + 5] = tmp;
    add_idle(4);

    // Random words with random mid-frame input churn.
    for (int f = 0; f < 15; f++) begin
      add_frame(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, quiet);
      add_idle(int'($urandom_range(1, 3)));
    end

    // Data_Valid held across two words: 0x3C then 0xC3.
    hold = '{rst: 1'b0, dv: 1'b1, d: 8'hC3, en: 1'b1, typ: 1'b1};
    add_frame(8'h3C, 1'b1, 1'b0, 1'b0, hold);
`ifndef TX_BACK_TO_BACK_EN
    push(hold, '{mux: 2'b01, ser: 1'b0, busy: 1'b0, par: last_par});
`endif
    add_frame(8'hC3, 1'b1, 1'b1, 1'b0, quiet);
    add_idle(2);

    // Reset while in PARITY, then a clean 0x5A frame.
    add_frame(DW'($urandom), 1'b1, 1'b1, 1'b0, quiet);
    void'(stim_q.pop_back());
    void'(exp_q.pop_back());
    add_reset();
    add_idle(2);
    add_frame(8'h5A, 1'b1, 1'b0, 1'b0, quiet);
    add_idle(3);

    for (int i = 0; i < stim_q.size(); i++) begin
      RST            = stim_q[i].rst;
      bus.Data_Valid = stim_q[i].dv;
      bus.P_DATA     = stim_q[i].d;
      bus.PAR_EN     = stim_q[i].en;
      bus.PAR_TYP    = stim_q[i].typ;
      @(posedge CLK);
      #1;
      o = '{mux: bus.MUX_sel, ser: bus.ser_data, busy: bus.busy, par: bus.par_bit};
      e = exp_q[i];
      chk("MUX_sel", i, {6'd0, o.mux}, {6'd0, e.mux});
      chk("ser_data", i, {7'd0, o.ser}, {7'd0, e.ser});
      chk("busy", i, {7'd0, o.busy}, {7'd0, e.busy});
      chk("par_bit", i, {7'd0, o.par}, {7'd0, e.par});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
